// File: rtl/msu_pkg.sv
// Shared widths and types for the modular squaring unit.
package msu_pkg;

    localparam int unsigned WordBits      = 16;
    localparam int unsigned SqSumBits     = 40;
    localparam int unsigned SqCarryBits   = SqSumBits - WordBits + 1;
    localparam int unsigned SqFlushDigits = (SqCarryBits + WordBits - 1) / WordBits;
    localparam int unsigned SqMaxCols     = 64;

    typedef enum logic {SQ_CS_RUN, SQ_CS_FLUSH} sq_cs_state_e;

endpackage

// File: rtl/sq_carry_serializer.sv
// Serial carry propagation of squarer column sums into WordBits-wide digits.
// Optional checks and column counter: define SQ_CARRY_SERIALIZER_CHECK_EN.
module sq_carry_serializer #(
    parameter int unsigned WordBits = msu_pkg::WordBits,
    parameter int unsigned SumBits  = msu_pkg::SqSumBits
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                valid_i,
    output logic                ready_o,
    input  logic [SumBits-1:0]  sum_i,
    input  logic                last_i,
    output logic                valid_o,
    input  logic                ready_i,
    output logic [WordBits-1:0] digit_o,
    output logic                last_o
);

    localparam int unsigned CarryBits   = SumBits - WordBits + 1;
    localparam int unsigned FlushDigits = (CarryBits + WordBits - 1) / WordBits;
    localparam int unsigned CntBits     = $clog2(FlushDigits + 1);

    msu_pkg::sq_cs_state_e state_q, state_d;
    logic [CarryBits-1:0]  carry_q, carry_d, carry_in;
    logic [CntBits-1:0]    cnt_q, cnt_d;
    logic                  valid_q, valid_d;
    logic [WordBits-1:0]   digit_q, digit_d;
    logic                  last_q, last_d;
    logic [SumBits:0]      sum_t;
    logic                  free;
    logic                  run_ok;
    logic                  accept;

    // Output register is free when empty or being drained this cycle.
    assign free = !valid_q || ready_i;

    // The final flush beat being accepted reopens the input in the same cycle.
    assign run_ok  = (state_q == msu_pkg::SQ_CS_RUN) ||
                     (cnt_q == '0 && valid_q && ready_i);
    assign ready_o = free && run_ok;
    assign accept  = valid_i && ready_o;

    assign carry_in = (state_q == msu_pkg::SQ_CS_RUN) ? carry_q : '0;
    assign sum_t    = (SumBits+1)'(sum_i) + (SumBits+1)'(carry_in);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= msu_pkg::SQ_CS_RUN;
            carry_q <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            digit_q <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            digit_q <= digit_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d = state_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        digit_d = digit_q;
        last_d  = last_q;

        case (state_q)
            msu_pkg::SQ_CS_RUN: begin
                if (free) valid_d = 1'b0;
            end
            msu_pkg::SQ_CS_FLUSH: begin
                if (cnt_q != '0) begin
                    if (free) begin
                        digit_d = WordBits'(carry_q);
                        carry_d = carry_q >> WordBits;
                        cnt_d   = cnt_q - CntBits'(1);
                        last_d  = (cnt_q == CntBits'(1));
                        valid_d = 1'b1;
                    end
                end else if (free) begin
                    state_d = msu_pkg::SQ_CS_RUN;
                    carry_d = '0;
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                end
            end
            default: state_d = msu_pkg::SQ_CS_RUN;
        endcase

        // Column load overrides the drain above; it shares the freed register.
        if (accept) begin
            digit_d = sum_t[WordBits-1:0];
            carry_d = sum_t[SumBits:WordBits];
            valid_d = 1'b1;
            last_d  = 1'b0;
            if (last_i) begin
                state_d = msu_pkg::SQ_CS_FLUSH;
                cnt_d   = CntBits'(FlushDigits);
            end else begin
                state_d = msu_pkg::SQ_CS_RUN;
            end
        end
    end

    assign valid_o = valid_q;
    assign digit_o = digit_q;
    assign last_o  = last_q;

`ifdef SQ_CARRY_SERIALIZER_CHECK_EN
    localparam int unsigned ColBits = $clog2(msu_pkg::SqMaxCols + 1);

    logic [ColBits-1:0] col_cnt_q;

    // Columns accepted so far in the current frame.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            col_cnt_q <= '0;
        end else if (accept) begin
            col_cnt_q <= last_i ? '0 : col_cnt_q + ColBits'(1);
        end
    end

    a_valid_hold: assert property (@(posedge clk_i) disable iff (!rst_ni)
        valid_i && !ready_o |=> valid_i);
    a_input_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        valid_i && !ready_o |=> $stable(sum_i) && $stable(last_i));
    a_output_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        valid_o && !ready_i |=> valid_o && $stable(digit_o) && $stable(last_o));
    a_carry_clear: assert property (@(posedge clk_i) disable iff (!rst_ni)
        state_q == msu_pkg::SQ_CS_FLUSH && cnt_q == '0 |-> carry_q == '0);
    a_max_cols: assert property (@(posedge clk_i) disable iff (!rst_ni)
        accept |-> 32'(col_cnt_q) < msu_pkg::SqMaxCols);
`endif

endmodule

// File: tb/tb_sq_carry_serializer.sv
// Directed self-checking bench for sq_carry_serializer (WordBits 16, SumBits 40).
module tb_sq_carry_serializer;

    logic        clk_i;
    logic        rst_ni;
    logic        valid_i;
    logic        ready_o;
    logic [39:0] sum_i;
    logic        last_i;
    logic        valid_o;
    logic        ready_i;
    logic [15:0] digit_o;
    logic        last_o;

    int total;
    int bad;

    logic [39:0] col_q[$];
    logic        col_l_q[$];
    logic [15:0] exp_d[$];
    logic        exp_l[$];
    logic [15:0] got_d[$];
    logic        got_l[$];
    int          acc_cyc[$];
    int          lhs_cyc[$];

    sq_carry_serializer #(.WordBits(16), .SumBits(40)) dut (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .sum_i   (sum_i),
        .last_i  (last_i),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .digit_o (digit_o),
        .last_o  (last_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic add_col(input logic [39:0] s, input logic l);
        col_q.push_back(s);
        col_l_q.push_back(l);
    endtask

    task automatic add_exp(input logic [15:0] d, input logic l);
        exp_d.push_back(d);
        exp_l.push_back(l);
    endtask

    task automatic clear_all();
        col_q.delete(); col_l_q.delete();
        exp_d.delete(); exp_l.delete();
        got_d.delete(); got_l.delete();
        acc_cyc.delete(); lhs_cyc.delete();
    endtask

    // Drive queued columns and collect digits; called and returns at a negedge.
    task automatic run_q(input int n_frames, input int stall_lo, input int stall_hi);
        int idx   = 0;
        int c     = 0;
        int lasts = 0;
        while (lasts < n_frames && c < 300) begin
            ready_i = !(c >= stall_lo && c < stall_hi);
            if (idx < col_q.size()) begin
                valid_i = 1'b1; sum_i = col_q[idx]; last_i = col_l_q[idx];
            end else begin
                valid_i = 1'b0; sum_i = '0; last_i = 1'b0;
            end
            #1;
            if (!ready_i && valid_o) begin
                chk("stall_ready_o", 64'(ready_o), 64'd0);
                if (got_d.size() < exp_d.size())
                    chk("stall_digit", 64'(digit_o), 64'(exp_d[got_d.size()]));
            end
            if (valid_o && ready_i) begin
                got_d.push_back(digit_o);
                got_l.push_back(last_o);
                if (last_o) begin
                    lasts++;
                    lhs_cyc.push_back(c);
                end
            end
            if (valid_i && ready_o) begin
                acc_cyc.push_back(c);
                idx++;
            end
            @(negedge clk_i);
            c++;
        end
        if (lasts < n_frames) chk("timeout_frames", 64'(lasts), 64'(n_frames));
        valid_i = 1'b0; sum_i = '0; last_i = 1'b0; ready_i = 1'b1;
    endtask

    task automatic cmp_out(input string name);
        chk({name, "_count"}, 64'(got_d.size()), 64'(exp_d.size()));
        for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
            chk($sformatf("%s_digit%0d", name, i), 64'(got_d[i]), 64'(exp_d[i]));
            chk($sformatf("%s_last%0d", name, i), 64'(got_l[i]), 64'(exp_l[i]));
        end
    endtask

    initial begin
        logic [127:0] big;
        logic [39:0]  cmax;
        total = 0; bad = 0;
        rst_ni = 1'b0; valid_i = 1'b0; sum_i = '0; last_i = 1'b0; ready_i = 1'b1;
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        #1;
        chk("rst_valid_o", 64'(valid_o), 64'd0);
        chk("rst_digit_o", 64'(digit_o), 64'd0);
        chk("rst_last_o", 64'(last_o), 64'd0);
        chk("rst_ready_o", 64'(ready_o), 64'd1);
        @(negedge clk_i);

        // Single column.
        clear_all();
        add_col(40'h12345, 1'b1);
        add_exp(16'h2345, 1'b0); add_exp(16'h0001, 1'b0); add_exp(16'h0000, 1'b1);
        run_q(1, -1, -1);
        cmp_out("single");

        // Carry chain, full-rate timing.
        clear_all();
        add_col(40'h1FFFF, 1'b0); add_col(40'h0FFFF, 1'b1);
        add_exp(16'hFFFF, 1'b0); add_exp(16'h0000, 1'b0);
        add_exp(16'h0001, 1'b0); add_exp(16'h0000, 1'b1);
        run_q(1, -1, -1);
        cmp_out("chain");
        if (acc_cyc.size() > 0 && lhs_cyc.size() > 0)
            chk("chain_throughput", 64'(lhs_cyc[0]), 64'(acc_cyc[0] + 4));
        else
            chk("chain_handshakes", 64'(acc_cyc.size() + lhs_cyc.size()), 64'd3);

        // Backpressure: ready_i low for cycles 1..3 while the first digit is held.
        clear_all();
        add_col(40'h12345, 1'b1);
        add_exp(16'h2345, 1'b0); add_exp(16'h0001, 1'b0); add_exp(16'h0000, 1'b1);
        run_q(1, 1, 4);
        cmp_out("stall");

        // Max stress against a golden wide sum.
        clear_all();
        cmax = 40'hFF_FFFF_FFFF;
        for (int i = 0; i < 3; i++) add_col(cmax, i == 2);
        big = 128'(cmax) + (128'(cmax) << 16) + (128'(cmax) << 32);
        for (int i = 0; i < 5; i++) add_exp(big[16*i +: 16], i == 4);
        run_q(1, -1, -1);
        cmp_out("stress");

        // Back-to-back frames; frame 2 waits through frame 1's flush.
        clear_all();
        add_col(40'h12345, 1'b1);
        add_col(40'h1FFFF, 1'b0); add_col(40'h0FFFF, 1'b1);
        add_exp(16'h2345, 1'b0); add_exp(16'h0001, 1'b0); add_exp(16'h0000, 1'b1);
        add_exp(16'hFFFF, 1'b0); add_exp(16'h0000, 1'b0);
        add_exp(16'h0001, 1'b0); add_exp(16'h0000, 1'b1);
        run_q(2, -1, -1);
        cmp_out("b2b");
        if (acc_cyc.size() > 1 && lhs_cyc.size() > 0)
            chk("b2b_same_cycle", 64'(acc_cyc[1]), 64'(lhs_cyc[0]));
        else
            chk("b2b_handshakes", 64'(acc_cyc.size()), 64'd3);

        // Reset mid-frame, then a fresh single-column frame.
        valid_i = 1'b1; sum_i = 40'h1FFFF; last_i = 1'b0; ready_i = 1'b1;
        @(negedge clk_i);
        valid_i = 1'b0; sum_i = '0;
        #1;
        chk("pre_rst_carry", 64'(dut.carry_q), 64'd1);
        rst_ni = 1'b0;
        #1;
        chk("mid_rst_valid_o", 64'(valid_o), 64'd0);
        chk("mid_rst_carry", 64'(dut.carry_q), 64'd0);
        chk("mid_rst_ready_o", 64'(ready_o), 64'd1);
        @(negedge clk_i);
        rst_ni = 1'b1;
        clear_all();
        add_col(40'h5, 1'b1);
        add_exp(16'h0005, 1'b0); add_exp(16'h0000, 1'b0); add_exp(16'h0000, 1'b1);
        run_q(1, -1, -1);
        cmp_out("post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sq_carry_serializer.md
# sq_carry_serializer

Serial carry-propagation stage directly downstream of the squarer column-sum trees. It accepts one column sum per beat, least-significant column first, adds the carry held from the previous column, and emits one normalized WordBits-wide digit per beat. After the final column it flushes the residual carry as extra digits, so each frame produces a fully carry-resolved square for the reduction logic.

## Interface
Parameters:
- WordBits, default msu_pkg::WordBits (16): output digit width.
- SumBits, default msu_pkg::SqSumBits: column-sum input width; must satisfy SumBits > WordBits.

Ports (one clock; reset is asynchronous and active-low):
- clk_i, input, 1: clock.
- rst_ni, input, 1: asynchronous active-low reset.
- valid_i, input, 1: sum_i/last_i valid.
- ready_o, output, 1: stage accepts the input beat.
- sum_i, input, SumBits: column sum from a sum-terms tree.
- last_i, input, 1: sum_i is the frame's most-significant column.
- valid_o, output, 1: digit_o/last_o valid.
- ready_i, input, 1: downstream accepts the output beat.
- digit_o, output, WordBits: normalized digit.
- last_o, output, 1: final digit of the frame.

## Operation
- CarryBits = SumBits − WordBits + 1; FlushDigits = ceil(CarryBits / WordBits).
- carry register: CarryBits wide. Flush counter: clog2(FlushDigits+1) bits.
- States: RUN, FLUSH.
- In RUN, an input beat is accepted when valid_i && ready_o:
  - t = sum_i + carry, computed SumBits+1 wide.
  - Output register loads t[WordBits-1:0].
  - carry <= t >> WordBits.
  - last_o = 0.
  - If last_i is set, go to FLUSH with the flush counter = FlushDigits.
- In FLUSH, ready_o = 0. Each time the output register is free:
  - Load carry[WordBits-1:0]; carry >>= WordBits; decrement the counter.
  - On the last flush digit, set last_o = 1.
  - When that beat is accepted downstream, go to RUN with carry = 0.
- Output register is a single stage. It is free when !valid_o || ready_i.
- In RUN, ready_o = free.
- While valid_o && !ready_i, digit_o and last_o hold stable.
- Frames are delimited only by last_i. Any number of columns is permitted, including 1.
- Arithmetic never overflows. The carry always fits in CarryBits because each column sum is below 2^SumBits.

## Timing
- Reset values:
  - valid_o = 0, digit_o = 0, last_o = 0.
  - carry = 0, state = RUN, flush counter = 0.
  - ready_o = 1 combinationally after reset (output register empty).
- Latency: 1 cycle from the input handshake to valid_o.
- Throughput: 1 digit/cycle with ready_i held high. Per frame: N columns in, N + FlushDigits digits out.
- Column-to-flush transition: the first flush digit follows the last column's digit on the next free cycle, with no bubble.
- Next frame: the first column is accepted in the same cycle the last_o beat is accepted. The FLUSH→RUN transition makes ready_o valid combinationally from that cycle.
- Simultaneous output accept and input accept in RUN: the register reloads in the same cycle, with no bubble.
- Reset asserted mid-frame: all state clears immediately. The partial frame is discarded; no last_o is produced for it.

## Configuration
- SQ_CARRY_SERIALIZER_CHECK_EN: compiles in SVA checks and a column counter (msu_pkg::SqMaxCols bound). The checks are:
  - valid_i is not dropped while !ready_o.
  - sum_i and last_i are stable while stalled.
  - digit_o and last_o are stable while stalled.
  - carry == 0 after the last flush digit.
  - The column count per frame is ≤ SqMaxCols.
- Without the macro, none of that logic exists and functional behaviour is identical.

## Structure
- msu_pkg holds:
  - SqCarryBits and SqFlushDigits localparams, derived from SqSumBits and WordBits.
  - SqMaxCols.
  - typedef enum logic {SQ_CS_RUN, SQ_CS_FLUSH} sq_cs_state_e.
- Single module; no sub-module. The output holding register is inline.

## Test plan
Test config: WordBits = 16, SumBits = 40, so CarryBits = 25 and FlushDigits = 2.
- Single column: sum_i = 0x12345, last_i = 1 → digits 0x2345, 0x0001, then 0x0000 with last_o = 1.
- Carry chain: columns 0x1FFFF, then 0xFFFF (last) → 0xFFFF, 0x0000, 0x0001, 0x0000 with last_o = 1.
- Backpressure: ready_i held low for 3 cycles with valid_o high → digit_o stable and ready_o = 0 throughout; no digit lost or duplicated.
- Max stress: 3 columns of 0xFF_FFFF_FFFF → digits match a golden big-integer sum of column·2^(16i), low digit first.
- Back-to-back frames: frame-2 valid_i presented during frame-1 flush → held off until the last_o handshake, then accepted the same cycle; results correct.
- Reset: rst_ni pulsed low mid-frame → valid_o = 0 and carry = 0 immediately; the next frame (single column 0x5) yields 0x0005, 0x0000, 0x0000 with last_o = 1.
